// File: rtl/pll_dyn_pkg.sv
// Shared types and helpers for the rPLL dynamic-divider controller.
package pll_dyn_pkg;

  typedef enum logic [2:0] {
    StApply,
    StLockWait,
    StSettle,
    StReady,
    StError
  } state_e;

  localparam int unsigned DivW  = 6;
  localparam int unsigned LostW = 8;

  // rPLL dynamic select pins take the inverted divide-by-minus-one value.
  function automatic logic [DivW-1:0] encode_div(input logic [DivW-1:0] sel, input bit invert);
    return invert ? ~sel : sel;
  endfunction

  // Timer width that holds the largest of the three count limits without wrapping.
  function automatic int unsigned timer_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pll_dyn_ctrl_if.sv
// Divider request handshake between user logic (master) and the PLL controller (slave).
interface pll_dyn_ctrl_if;
  import pll_dyn_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic [DivW-1:0] req_fdiv;
  logic [DivW-1:0] req_idiv;

  modport master (output req_valid, output req_fdiv, output req_idiv, input req_ready);
  modport slave (input req_valid, input req_fdiv, input req_idiv, output req_ready);

endinterface

// File: rtl/pll_lock_sync.sv
// Two-flop synchroniser for the asynchronous PLL lock indication.
module pll_lock_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic sync_o
);

  logic [1:0] stage_q, stage_d;

  always_comb begin
    stage_d = {stage_q[0], async_i};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stage_q <= 2'b00;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign sync_o = stage_q[1];

endmodule

// File: rtl/pll_dyn_ctrl.sv
// Dynamic divider / reset sequencer for a Gowin rPLL: applies divider settings, holds the PLL
// in reset, waits for a debounced lock, reports ready and retries on lock timeout.
module pll_dyn_ctrl
  import pll_dyn_pkg::*;
#(
  parameter logic [DivW-1:0] FDIV_INIT     = '0,
  parameter logic [DivW-1:0] IDIV_INIT     = '0,
  parameter bit              INVERT_SEL    = 1'b1,
  parameter int unsigned     RESET_CYCLES  = 16,
  parameter int unsigned     LOCK_TIMEOUT  = 65535,
  parameter int unsigned     STABLE_CYCLES = 256,
  parameter int unsigned     MAX_RETRY     = 3
) (
  input  logic             clkin,
  input  logic             reset,
  pll_dyn_ctrl_if.slave    req,
  input  logic             pll_lock,
  output logic             pll_reset,
  output logic             pll_reset_p,
  output logic [DivW-1:0]  pll_fdiv,
  output logic [DivW-1:0]  pll_idiv,
  output logic             ready,
  output logic             busy,
  output logic             err,
  output logic [LostW-1:0] lock_lost_cnt
);

  localparam int unsigned TimerW = timer_width(RESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int unsigned RetryW = $clog2(MAX_RETRY + 2);

  localparam logic [TimerW-1:0] ResetLast   = TimerW'(RESET_CYCLES - 1);
  localparam logic [TimerW-1:0] TimeoutLast = TimerW'(LOCK_TIMEOUT - 1);
  localparam logic [TimerW-1:0] StableLast  = TimerW'(STABLE_CYCLES - 1);
  localparam logic [RetryW-1:0] RetryMax    = RetryW'(MAX_RETRY);
  localparam logic [DivW-1:0]   FdivRst     = encode_div(FDIV_INIT, INVERT_SEL);
  localparam logic [DivW-1:0]   IdivRst     = encode_div(IDIV_INIT, INVERT_SEL);

  logic lock_s;

  pll_lock_sync u_lock_sync (
    .clk_i  (clkin),
    .rst_i  (reset),
    .async_i(pll_lock),
    .sync_o (lock_s)
  );

  state_e            state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [RetryW-1:0] retry_q, retry_d;
  logic [DivW-1:0]   fdiv_q, fdiv_d;
  logic [DivW-1:0]   idiv_q, idiv_d;
  logic [LostW-1:0]  lost_q, lost_d;
  logic              err_q, err_d;
  logic              pll_reset_q, pll_reset_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              req_ready_q, req_ready_d;
  logic              req_hs;

  assign req_hs = req.req_valid & req_ready_q;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    retry_d = retry_q;
    fdiv_d  = fdiv_q;
    idiv_d  = idiv_q;
    lost_d  = lost_q;
    err_d   = err_q;

    unique case (state_q)
      StApply: begin
        if (timer_q == ResetLast) begin
          state_d = StLockWait;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      StLockWait: begin
        if (lock_s) begin
          // The cycle lock is first seen already counts towards the stable run.
          if (STABLE_CYCLES <= 1) begin
            state_d = StReady;
            timer_d = '0;
            retry_d = '0;
          end else begin
            state_d = StSettle;
            timer_d = TimerW'(1);
          end
        end else if (timer_q == TimeoutLast) begin
          timer_d = '0;
          retry_d = retry_q + RetryW'(1);
          if (retry_q >= RetryMax) begin
            state_d = StError;
            err_d   = 1'b1;
          end else begin
            state_d = StApply;
          end
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      StSettle: begin
        if (!lock_s) begin
          state_d = StLockWait;
          timer_d = '0;
        end else if (timer_q == StableLast) begin
          state_d = StReady;
          timer_d = '0;
          retry_d = '0;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      StReady: begin
        if (!lock_s) begin
          if (lost_q != '1) lost_d = lost_q + LostW'(1);
          state_d = StApply;
          timer_d = '0;
        end
        // A request in the same cycle as a lock drop still takes its new dividers.
        if (req_hs) begin
          fdiv_d  = encode_div(req.req_fdiv, INVERT_SEL);
          idiv_d  = encode_div(req.req_idiv, INVERT_SEL);
          state_d = StApply;
          timer_d = '0;
        end
      end
      StError: begin
        if (req_hs) begin
          fdiv_d  = encode_div(req.req_fdiv, INVERT_SEL);
          idiv_d  = encode_div(req.req_idiv, INVERT_SEL);
          err_d   = 1'b0;
          retry_d = '0;
          state_d = StApply;
          timer_d = '0;
        end
      end
      default: begin
        state_d = StApply;
        timer_d = '0;
      end
    endcase

    pll_reset_d = (state_d == StApply) || (state_d == StError);
    ready_d     = (state_d == StReady);
    busy_d      = state_d inside {StApply, StLockWait, StSettle};
    req_ready_d = (state_d == StReady) || (state_d == StError);
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q     <= StApply;
      timer_q     <= '0;
      retry_q     <= '0;
      fdiv_q      <= FdivRst;
      idiv_q      <= IdivRst;
      lost_q      <= '0;
      err_q       <= 1'b0;
      pll_reset_q <= 1'b1;
      ready_q     <= 1'b0;
      busy_q      <= 1'b1;
      req_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
      fdiv_q      <= fdiv_d;
      idiv_q      <= idiv_d;
      lost_q      <= lost_d;
      err_q       <= err_d;
      pll_reset_q <= pll_reset_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      req_ready_q <= req_ready_d;
    end
  end

  assign pll_reset     = pll_reset_q;
  assign pll_reset_p   = pll_reset_q;
  assign pll_fdiv      = fdiv_q;
  assign pll_idiv      = idiv_q;
  assign ready         = ready_q;
  assign busy          = busy_q;
  assign err           = err_q;
  assign lock_lost_cnt = lost_q;
  assign req.req_ready = req_ready_q;

endmodule

// File: tb/tb_pll_dyn_ctrl.sv
// Bench for pll_dyn_ctrl: instance 0 uses the default timing, instance 1 uses short timers,
// pass-through encoding and a small lock timeout for retry and saturation runs.
module tb_pll_dyn_ctrl;

  localparam int ResetCyc  [2] = '{16, 4};
  localparam int StableCyc [2] = '{256, 8};
  localparam bit Inv       [2] = '{1'b1, 1'b0};
  localparam int InitF     [2] = '{0, 3};
  localparam int InitI     [2] = '{0, 2};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst  [2];
  logic       lock [2];
  logic       rv   [2];
  logic [5:0] rf   [2];
  logic [5:0] ri   [2];
  wire        rr    [2];
  wire        prst  [2];
  wire        prstp [2];
  wire        rdy   [2];
  wire        bsy   [2];
  wire        er    [2];
  wire  [5:0] pf    [2];
  wire  [5:0] pi    [2];
  wire  [7:0] llc   [2];

  pll_dyn_ctrl_if if_a ();
  pll_dyn_ctrl_if if_b ();

  assign if_a.req_valid = rv[0];
  assign if_a.req_fdiv  = rf[0];
  assign if_a.req_idiv  = ri[0];
  assign rr[0]          = if_a.req_ready;
  assign if_b.req_valid = rv[1];
  assign if_b.req_fdiv  = rf[1];
  assign if_b.req_idiv  = ri[1];
  assign rr[1]          = if_b.req_ready;

  pll_dyn_ctrl u_dut_a (
    .clkin        (clk),
    .reset        (rst[0]),
    .req          (if_a),
    .pll_lock     (lock[0]),
    .pll_reset    (prst[0]),
    .pll_reset_p  (prstp[0]),
    .pll_fdiv     (pf[0]),
    .pll_idiv     (pi[0]),
    .ready        (rdy[0]),
    .busy         (bsy[0]),
    .err          (er[0]),
    .lock_lost_cnt(llc[0])
  );

  pll_dyn_ctrl #(
    .FDIV_INIT    (6'd3),
    .IDIV_INIT    (6'd2),
    .INVERT_SEL   (1'b0),
    .RESET_CYCLES (4),
    .LOCK_TIMEOUT (50),
    .STABLE_CYCLES(8),
    .MAX_RETRY    (3)
  ) u_dut_b (
    .clkin        (clk),
    .reset        (rst[1]),
    .req          (if_b),
    .pll_lock     (lock[1]),
    .pll_reset    (prst[1]),
    .pll_reset_p  (prstp[1]),
    .pll_fdiv     (pf[1]),
    .pll_idiv     (pi[1]),
    .ready        (rdy[1]),
    .busy         (bsy[1]),
    .err          (er[1]),
    .lock_lost_cnt(llc[1])
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: divider values the PLL should see and the expected drop count.
  logic [5:0] m_f    [2];
  logic [5:0] m_i    [2];
  int         m_lost [2];

  function automatic logic [5:0] enc(input int s, input logic [5:0] x);
    return Inv[s] ? 6'h3F - x : x;
  endfunction

  function automatic int sat(input int x);
    return (x > 255) ? 255 : x;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_prst(input int s, input logic val, input int limit, output int n);
    n = 0;
    while (prst[s] !== val && n < limit) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_rdy(input int s, input int limit, output int n);
    n = 0;
    while (rdy[s] !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
  endtask

  task automatic check_reset_state(input int s, input string tag);
    check_eq({tag, "_prst"}, prst[s], 1);
    check_eq({tag, "_prstp"}, prstp[s], 1);
    check_eq({tag, "_fdiv"}, pf[s], enc(s, 6'(InitF[s])));
    check_eq({tag, "_idiv"}, pi[s], enc(s, 6'(InitI[s])));
    check_eq({tag, "_ready"}, rdy[s], 0);
    check_eq({tag, "_busy"}, bsy[s], 1);
    check_eq({tag, "_err"}, er[s], 0);
    check_eq({tag, "_reqrdy"}, rr[s], 0);
    check_eq({tag, "_lost"}, llc[s], 0);
  endtask

  // Called on the cycle pll_reset is high at the start of an attempt.
  task automatic bring_up(input int s, input int delay, input string tag);
    int n;
    lock[s] = 1'b0;
    check_eq({tag, "_busy0"}, bsy[s], 1);
    wait_prst(s, 1'b0, 1000, n);
    check_eq({tag, "_reset_len"}, n, ResetCyc[s]);
    check_eq({tag, "_prstp_low"}, prstp[s], 0);
    check_eq({tag, "_fdiv"}, pf[s], m_f[s]);
    check_eq({tag, "_idiv"}, pi[s], m_i[s]);
    tick_n(delay);
    lock[s] = 1'b1;
    wait_rdy(s, 2000, n);
    check_eq({tag, "_ready_lat"}, n, 2 + StableCyc[s]);
    check_eq({tag, "_busy1"}, bsy[s], 0);
    check_eq({tag, "_reqrdy"}, rr[s], 1);
    check_eq({tag, "_lost"}, llc[s], sat(m_lost[s]));
  endtask

  task automatic request(input int s, input logic [5:0] f, input logic [5:0] i, input string tag);
    rv[s] = 1'b1;
    rf[s] = f;
    ri[s] = i;
    tick();
    rv[s]   = 1'b0;
    lock[s] = 1'b0;
    m_f[s]  = enc(s, f);
    m_i[s]  = enc(s, i);
    check_eq({tag, "_req_prst"}, prst[s], 1);
    check_eq({tag, "_req_ready"}, rdy[s], 0);
    check_eq({tag, "_req_busy"}, bsy[s], 1);
    check_eq({tag, "_req_reqrdy"}, rr[s], 0);
    check_eq({tag, "_req_fdiv"}, pf[s], m_f[s]);
    check_eq({tag, "_req_idiv"}, pi[s], m_i[s]);
    check_eq({tag, "_req_err"}, er[s], 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int n;
    int cnt;
    for (int s = 0; s < 2; s++) begin
      rst[s]    = 1'b1;
      lock[s]   = 1'b0;
      rv[s]     = 1'b0;
      rf[s]     = '0;
      ri[s]     = '0;
      m_f[s]    = enc(s, 6'(InitF[s]));
      m_i[s]    = enc(s, 6'(InitI[s]));
      m_lost[s] = 0;
    end
    tick_n(4);
    check_reset_state(0, "rsta");
    check_reset_state(1, "rstb");
    check_eq("pwr_fdiv_lit", pf[0], 6'h3F);

    // Power-up on instance 0
    rst[0] = 1'b0;
    bring_up(0, 100, "pwr");

    // Reconfigure: fixed then random dividers
    request(0, 6'd5, 6'd1, "cfg");
    check_eq("cfg_fdiv_lit", pf[0], 6'h3A);
    check_eq("cfg_idiv_lit", pi[0], 6'h3E);
    bring_up(0, $urandom_range(1, 150), "cfg");
    repeat (3) begin
      request(0, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), "rcfg");
      bring_up(0, $urandom_range(1, 150), "rcfg");
    end

    // Lock glitches during settle; a request held while busy is ignored
    request(0, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), "glt");
    wait_prst(0, 1'b0, 100, n);
    check_eq("glt_reset_len", n, 16);
    rv[0] = 1'b1;
    rf[0] = 6'($urandom_range(0, 63));
    ri[0] = 6'($urandom_range(0, 63));
    cnt   = 0;
    repeat (20) begin
      tick();
      if (rr[0] !== 1'b0) cnt++;
    end
    rv[0] = 1'b0;
    check_eq("busy_reqrdy_low", cnt, 0);
    check_eq("busy_fdiv_kept", pf[0], m_f[0]);
    check_eq("busy_idiv_kept", pi[0], m_i[0]);
    lock[0] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick_n((k == 0) ? 103 : $urandom_range(5, 250));
      lock[0] = 1'b0;
      tick_n((k == 0) ? 3 : $urandom_range(1, 8));
      lock[0] = 1'b1;
    end
    wait_rdy(0, 1000, n);
    check_eq("glt_ready_lat", n, 258);

    // Lock loss while ready
    for (int k = 0; k < 10; k++) begin
      lock[0] = 1'b0;
      wait_prst(0, 1'b1, 20, n);
      check_eq("drop_detect", n, 3);
      m_lost[0]++;
      check_eq("drop_cnt", llc[0], sat(m_lost[0]));
      check_eq("drop_ready", rdy[0], 0);
      bring_up(0, $urandom_range(1, 20), "drop");
    end
    check_eq("drop_cnt10", llc[0], 10);

    // Reset in the middle of settle with request-updated dividers
    request(0, 6'($urandom_range(1, 63)), 6'($urandom_range(1, 63)), "mid");
    wait_prst(0, 1'b0, 100, n);
    tick_n(10);
    lock[0] = 1'b1;
    tick_n(50);
    check_eq("mid_settle_busy", bsy[0], 1);
    check_eq("mid_settle_ready", rdy[0], 0);
    rst[0] = 1'b1;
    tick();
    lock[0]   = 1'b0;
    m_f[0]    = enc(0, 6'(InitF[0]));
    m_i[0]    = enc(0, 6'(InitI[0]));
    m_lost[0] = 0;
    check_reset_state(0, "mid");
    tick_n(2);
    rst[0] = 1'b0;
    bring_up(0, 20, "rec");

    // Instance 1: lock never rises -> four attempts then error
    rst[1] = 1'b0;
    check_eq("to_fdiv_init", pf[1], 6'd3);
    check_eq("to_idiv_init", pi[1], 6'd2);
    for (int a = 0; a < 4; a++) begin
      wait_prst(1, 1'b0, 100, n);
      check_eq("to_reset_len", n, 4);
      wait_prst(1, 1'b1, 200, n);
      check_eq("to_wait_len", n, 50);
      check_eq("to_err", er[1], (a == 3) ? 1 : 0);
    end
    check_eq("err_reqrdy", rr[1], 1);
    check_eq("err_busy", bsy[1], 0);
    check_eq("err_ready", rdy[1], 0);
    cnt = 0;
    repeat (100) begin
      tick();
      if (prst[1] !== 1'b1) cnt++;
    end
    check_eq("err_prst_stuck", cnt, 0);
    check_eq("err_sticky", er[1], 1);
    request(1, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), "errclr");
    bring_up(1, $urandom_range(1, 30), "errclr");

    // Request coinciding with lock loss: request wins, count still steps
    lock[1] = 1'b0;
    tick_n(2);
    m_lost[1]++;
    request(1, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), "both");
    check_eq("both_cnt", llc[1], sat(m_lost[1]));
    bring_up(1, $urandom_range(1, 30), "both");

    // Saturation of the lock-loss counter
    for (int k = 0; k < 300; k++) begin
      lock[1] = 1'b0;
      wait_prst(1, 1'b1, 20, n);
      check_eq("sat_detect", n, 3);
      m_lost[1]++;
      check_eq("sat_cnt", llc[1], sat(m_lost[1]));
      bring_up(1, $urandom_range(1, 5), "sat");
    end
    check_eq("sat_final", llc[1], 255);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
